// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg
// Shared types and helpers for the streaming CRC engine.
//   state_t   : frame FSM states (IDLE, RUN, DONE)
//   crc_step  : folds a data_w-bit beat into a crc_w-bit register, MSB first.
//               It works on 32/64-bit containers so one function serves every width.
`timescale 1ns/1ps
package crc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_CRC_W  = 32;
  localparam int MAX_DATA_W = 64;

  function automatic logic [MAX_CRC_W-1:0] crc_step(
    input logic [MAX_CRC_W-1:0]  crc,
    input logic [MAX_DATA_W-1:0] data,
    input logic [MAX_CRC_W-1:0]  poly,
    input int                    crc_w,
    input int                    data_w
  );
    logic [MAX_CRC_W-1:0] c;
    logic [MAX_CRC_W-1:0] mask;
    logic                 fb;
    mask = (crc_w >= MAX_CRC_W) ? '1 : ((MAX_CRC_W'(1) << crc_w) - MAX_CRC_W'(1));
    c    = crc & mask;
    // Walk from the top container bit down; only the low data_w bits are real data.
    for (int i = MAX_DATA_W - 1; i >= 0; i--) begin
      if (i < data_w) begin
        fb = c[crc_w-1] ^ data[i];
        c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_stream_step.sv
// crc_stream_step
// Purely combinational: applies DATA_W serial CRC steps in one pass.
//   crc_in  [CRC_W]  : current register value
//   data    [DATA_W] : beat, MSB processed first
//   crc_out [CRC_W]  : register value after the whole beat
`timescale 1ns/1ps
module crc_stream_step
  import crc_stream_pkg::*;
#(
  parameter int               CRC_W  = 10,
  parameter int               DATA_W = 10,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(10'h24F)
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [MAX_CRC_W-1:0] step_res;

  assign step_res = crc_step(MAX_CRC_W'(crc_in), MAX_DATA_W'(data),
                             MAX_CRC_W'(POLY), CRC_W, DATA_W);
  assign crc_out  = CRC_W'(step_res);

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine
// Streaming CRC generator/checker. One DATA_W-bit beat per cycle is folded into
// a CRC_W-bit register; at the end of each frame the finalised CRC, the
// (saturating) beat count and an optional residue-match flag are held until
// the consumer takes them.
// Ports:
//   clk, rst (async, active-high), clr (sync abort)
//   s_valid/s_ready/s_data/s_last : input beat stream
//   m_valid/m_ready               : result handshake
//   m_crc   : crc register ^ XOR_OUT
//   m_beats : beats in frame, saturating at all-ones
//   m_match : final register == CHECK_RESIDUE
// Build option: define CRC_STREAM_CHECK_EN to include the residue compare;
// otherwise m_match is tied low.
`timescale 1ns/1ps
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int               CRC_W         = 10,
  parameter int               DATA_W        = 10,
  parameter logic [CRC_W-1:0] POLY          = CRC_W'(10'h24F),
  parameter logic [CRC_W-1:0] INIT          = '0,
  parameter logic [CRC_W-1:0] XOR_OUT       = '0,
  parameter int               CNT_W         = 16,
  parameter logic [CRC_W-1:0] CHECK_RESIDUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CRC_W-1:0]  m_crc,
  output logic [CNT_W-1:0]  m_beats,
  output logic              m_match
);

  state_t           state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CNT_W-1:0] beats_q;
  logic [CNT_W-1:0] beats_d;
  logic             accept;

  crc_stream_step #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .data    (s_data),
    .crc_out (crc_d)
  );

  assign beats_d = (&beats_q) ? beats_q : beats_q + 1'b1;
  assign s_ready = (state_q != DONE);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      beats_q <= '0;
    end else if (clr) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      beats_q <= '0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (accept) begin
            crc_q   <= crc_d;
            beats_q <= beats_d;
            state_q <= s_last ? DONE : RUN;
          end
        end
        DONE: begin
          if (m_ready) begin
            crc_q   <= INIT;
            beats_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CRC_STREAM_CHECK_EN
  logic match_q;

  // Compare the value being written on the last beat so the flag lands
  // together with the result it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
    end else if (clr) begin
      match_q <= 1'b0;
    end else if (accept && s_last) begin
      match_q <= (crc_d == CHECK_RESIDUE);
    end else if (state_q == DONE && m_ready) begin
      match_q <= 1'b0;
    end
  end

  assign m_match = match_q;
`else
  logic residue_unused;
  assign residue_unused = ^CHECK_RESIDUE;
  assign m_match        = 1'b0;
`endif

  assign m_valid = (state_q == DONE);
  assign m_crc   = crc_q ^ XOR_OUT;
  assign m_beats = beats_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
`timescale 1ns/1ps
module tb_crc_stream_engine;

  logic       clk = 1'b0;
  logic       rst, clr, s_valid, s_last, m_ready;
  logic [7:0] s_data;

  logic        a_s_ready, a_m_valid, a_m_match;
  logic [7:0]  a_m_crc;
  logic [15:0] a_m_beats;
  logic        b_s_ready, b_m_valid, b_m_match;
  logic [15:0] b_m_crc;
  logic [15:0] b_m_beats;
  logic        c_s_ready, c_m_valid, c_m_match;
  logic [7:0]  c_m_crc;
  logic [1:0]  c_m_beats;

  // A: CRC-8/SMBUS, B: CRC-16/CCITT-FALSE, C: CRC-8 with XOR_OUT and 2-bit counter
  crc_stream_engine #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00),
                      .XOR_OUT(8'h00), .CNT_W(16), .CHECK_RESIDUE(8'h00)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(a_s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(a_m_valid), .m_ready(m_ready),
    .m_crc(a_m_crc), .m_beats(a_m_beats), .m_match(a_m_match));

  crc_stream_engine #(.CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF),
                      .XOR_OUT(16'h0000), .CNT_W(16), .CHECK_RESIDUE(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(b_s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(b_m_valid), .m_ready(m_ready),
    .m_crc(b_m_crc), .m_beats(b_m_beats), .m_match(b_m_match));

  crc_stream_engine #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00),
                      .XOR_OUT(8'h55), .CNT_W(2), .CHECK_RESIDUE(8'h00)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(c_s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(c_m_valid), .m_ready(m_ready),
    .m_crc(c_m_crc), .m_beats(c_m_beats), .m_match(c_m_match));

  always #5 clk = ~clk;

`ifdef CRC_STREAM_CHECK_EN
  localparam bit MATCH_EN = 1'b1;
`else
  localparam bit MATCH_EN = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] msg[$];
  logic [7:0] digits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Table-driven (byte-at-a-time) CRC over a whole message, MSB-first.
  function automatic logic [31:0] ref_crc(input logic [7:0] m[$], input int w,
                                          input logic [31:0] poly, input logic [31:0] init);
    logic [31:0] tbl [256];
    logic [31:0] mask, r, crc;
    logic [7:0]  idx;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int b = 0; b < 256; b++) begin
      r = 32'(b) << (w - 8);
      for (int k = 0; k < 8; k++) begin
        r = r[w-1] ? ((r << 1) ^ poly) : (r << 1);
        r = r & mask;
      end
      tbl[b] = r;
    end
    crc = init & mask;
    foreach (m[i]) begin
      idx = 8'((crc >> (w - 8)) ^ 32'(m[i]));
      crc = ((crc << 8) ^ tbl[idx]) & mask;
    end
    return crc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_a_ready"}, a_s_ready, 1);
    chk({tag, "_a_valid"}, a_m_valid, 0);
    chk({tag, "_a_crc"},   a_m_crc,   8'h00);
    chk({tag, "_a_beats"}, a_m_beats, 0);
    chk({tag, "_a_match"}, a_m_match, 0);
    chk({tag, "_b_crc"},   b_m_crc,   16'hFFFF);
    chk({tag, "_b_valid"}, b_m_valid, 0);
    chk({tag, "_c_crc"},   c_m_crc,   8'h55);
    chk({tag, "_c_beats"}, c_m_beats, 0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] m[$]);
    logic [31:0] ra, rb;
    int n;
    ra = ref_crc(m, 8, 32'h07, 32'h00);
    rb = ref_crc(m, 16, 32'h1021, 32'hFFFF);
    n  = m.size();
    chk({tag, "_a_valid"}, a_m_valid, 1);
    chk({tag, "_a_ready"}, a_s_ready, 0);
    chk({tag, "_a_crc"},   a_m_crc,   ra);
    chk({tag, "_a_beats"}, a_m_beats, n);
    chk({tag, "_a_match"}, a_m_match, MATCH_EN && (ra == 0));
    chk({tag, "_b_valid"}, b_m_valid, 1);
    chk({tag, "_b_crc"},   b_m_crc,   rb);
    chk({tag, "_b_beats"}, b_m_beats, n);
    chk({tag, "_b_match"}, b_m_match, MATCH_EN && (rb == 0));
    chk({tag, "_c_crc"},   c_m_crc,   ra ^ 32'h55);
    chk({tag, "_c_beats"}, c_m_beats, (n > 3) ? 3 : n);
    chk({tag, "_c_match"}, c_m_match, MATCH_EN && (ra == 0));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int guard;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    guard   = 0;
    while (!a_s_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("s_ready_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] m[$], input bit gaps);
    foreach (m[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_beat(m[i], i == m.size() - 1);
    end
  endtask

  // Result is present; hold m_ready low for 'hold' cycles, then consume it.
  task automatic consume(input string tag, input logic [7:0] m[$], input int hold);
    check_result(tag, m);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_result({tag, "_hold"}, m);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    digits = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Check value frame with result consumed right away: one-cycle bubble
    send_frame(digits, 1'b0);
    chk("a_crc_known", a_m_crc, 8'hF4);
    chk("b_crc_known", b_m_crc, 16'h29B1);
    consume("check9", digits, 0);

    // Same frame with a 5-cycle consumer stall
    send_frame(digits, 1'b1);
    consume("stall5", digits, 5);

    // Residue check: message followed by its own CRC, then a corrupted copy
    msg = digits;
    msg.push_back(8'hF4);
    send_frame(msg, 1'b0);
    consume("residue_good", msg, 0);
    msg[3] = msg[3] ^ 8'h01;
    send_frame(msg, 1'b0);
    consume("residue_bad", msg, 1);

    // clr mid-frame with a beat presented in the same cycle
    msg = digits[0:3];
    send_frame(msg, 1'b0);
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check_idle("clr_mid");
    send_frame(digits, 1'b0);
    consume("after_clr", digits, 0);

    // clr while a result is held
    send_frame(digits, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_idle("clr_done");

    // Asynchronous reset mid-frame
    msg = digits[0:3];
    send_frame(msg, 1'b0);
    #2 rst = 1'b1;
    #1 check_idle("rst_mid");
    rst = 1'b0;
    tick();
    send_frame(digits, 1'b0);
    consume("after_rst", digits, 0);

    // Back-to-back single-beat frames, s_valid held high throughout
    m_ready = 1'b1;
    s_valid = 1'b1; s_last = 1'b1; s_data = 8'h00;
    tick();
    msg = {8'h00};
    check_result("b2b0", msg);
    chk("b2b0_a_crc", a_m_crc, 8'h00);
    s_data = 8'h01;
    tick();
    chk("b2b_bubble_ready", a_s_ready, 1);
    chk("b2b_bubble_valid", a_m_valid, 0);
    tick();
    msg = {8'h01};
    check_result("b2b1", msg);
    chk("b2b1_a_crc", a_m_crc, 8'h07);
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    m_ready = 1'b0;
    check_idle("b2b_end");

    // 6-beat frame: C's 2-bit counter saturates at 3
    msg = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    send_frame(msg, 1'b0);
    chk("sat_c_beats", c_m_beats, 3);
    consume("sat6", msg, 0);

    // Random frames, random gaps and consumer stalls
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 12);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      send_frame(msg, 1'b1);
      consume($sformatf("rand%0d", f), msg, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
